// File: rtl/activation_unit_if.sv
// activation_unit_if: start/select/vector bus between the sequencer and activation_unit.
interface activation_unit_if #(parameter int N_NODES = 10, parameter int DATA_W = 16);
  localparam int CNT_W = $clog2(N_NODES + 1);
  logic start;
  logic [1:0] act_sel;
  logic [CNT_W-1:0] num_active;
  logic [N_NODES-1:0][DATA_W-1:0] d_in;
  logic [N_NODES-1:0][DATA_W-1:0] d_out;
  logic busy;
  logic done;
  modport master(output start, act_sel, num_active, d_in, input d_out, busy, done);
  modport slave(input start, act_sel, num_active, d_in, output d_out, busy, done);
endinterface

// File: rtl/activation_unit.sv
// activation_unit: one-node-per-cycle identity/PWL-sigmoid/ReLU over a captured vector, 2-stage pipe.
// ReLU on act_sel=10 only when ACTIVATION_RELU_EN is defined; otherwise act_sel=10 is identity.
module activation_unit #(
  parameter int N_NODES = 10,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input logic clk,
  input logic reset,
  activation_unit_if.slave bus
);
  localparam int CNT_W = $clog2(N_NODES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_NODES - 1);
  localparam logic [CNT_W-1:0] NMAX = CNT_W'(N_NODES);
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1 << FRAC_W);
  localparam logic [DATA_W-1:0] K5 = DATA_W'(5 << FRAC_W);
  localparam logic [DATA_W-1:0] K2375 = DATA_W'((19 << FRAC_W) >> 3);
  localparam logic [DATA_W-1:0] C216 = DATA_W'((27 << FRAC_W) >> 5);
  localparam logic [DATA_W-1:0] C160 = DATA_W'((5 << FRAC_W) >> 3);
  localparam logic [DATA_W-1:0] C128 = DATA_W'((1 << FRAC_W) >> 1);
  localparam logic [DATA_W-1:0] MAXP = {1'b0, {(DATA_W-1){1'b1}}};
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, WAIT_LOW} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] idx, cnt, idx1;
  logic [1:0] sel;
  logic [N_NODES-1:0][DATA_W-1:0] x_r, d_out;
  logic [DATA_W-1:0] xi, ax, ax1, x1, y, sig, res;
  logic [1:0] seg, seg1;
  logic v1, live1, neg1, relu_on;
`ifdef ACTIVATION_RELU_EN
  assign relu_on = sel == 2'b10;
`else
  assign relu_on = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.start ? RUN : IDLE;
      RUN: state_nx = idx == LAST ? DRAIN : RUN;
      DRAIN: state_nx = DONE;
      DONE: state_nx = bus.start ? WAIT_LOW : IDLE;
      WAIT_LOW: state_nx = bus.start ? WAIT_LOW : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    bus.busy = state == RUN || state == DRAIN || state == DONE;
    bus.done = state == DONE;
  end
  assign bus.d_out = d_out;
  // stage 1: magnitude (most-negative saturates) and sigmoid segment
  always_comb begin
    xi = x_r[idx];
    ax = !xi[DATA_W-1] ? xi : xi[DATA_W-2:0] == '0 ? MAXP : -xi;
    seg = ax >= K5 ? 2'd3 : ax >= K2375 ? 2'd2 : ax >= ONE ? 2'd1 : 2'd0;
  end
  // stage 2: segment add/shift, mirror for negative inputs, lane masking
  always_comb begin
    y = seg1 == 2'd3 ? ONE : seg1 == 2'd2 ? (ax1 >> 5) + C216 :
        seg1 == 2'd1 ? (ax1 >> 3) + C160 : (ax1 >> 2) + C128;
    sig = neg1 ? ONE - y : y;
    res = !live1 ? '0 : sel == 2'b01 ? sig : (relu_on && x1[DATA_W-1]) ? '0 : x1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      cnt <= '0;
      sel <= '0;
      x_r <= '0;
      d_out <= '0;
      v1 <= 1'b0;
      idx1 <= '0;
      live1 <= 1'b0;
      neg1 <= 1'b0;
      seg1 <= '0;
      x1 <= '0;
      ax1 <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        x_r <= bus.d_in;
        sel <= bus.act_sel;
        cnt <= bus.num_active > NMAX ? NMAX : bus.num_active;
        idx <= '0;
      end else if (state == RUN && idx != LAST) begin
        idx <= idx + 1'b1;
      end
      v1 <= state == RUN;
      if (state == RUN) begin
        idx1 <= idx;
        live1 <= idx < cnt;
        x1 <= xi;
        ax1 <= ax;
        neg1 <= xi[DATA_W-1];
        seg1 <= seg;
      end
      if (v1)
        d_out[idx1] <= res;
    end
  end
endmodule

// File: tb/tb_activation_unit.sv
// tb_activation_unit: directed vectors, expected results queued at issue and checked by a done monitor.
module tb_activation_unit;
  localparam int N = 10;
  localparam int W = 16;
  typedef struct {
    logic [N-1:0][W-1:0] v;
    int cyc;
  } exp_t;
  logic clk = 0;
  logic reset = 1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int vin[N];
  int vexp[N];
  exp_t q[$];
  activation_unit_if #(.N_NODES(N), .DATA_W(W)) bus();
  activation_unit #(.N_NODES(N), .DATA_W(W), .FRAC_W(8)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && bus.done) begin
      done_cnt++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d got done=1 want done=0", cyc);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL done_latency got cyc=%0d want cyc=%0d", cyc, e.cyc);
        end
        for (int i = 0; i < N; i++) begin
          checks++;
          if (bus.d_out[i] !== e.v[i]) begin
            errors++;
            $display("FAIL d_out[%0d] got %0d want %0d", i, $signed(bus.d_out[i]), $signed(e.v[i]));
          end
        end
      end
    end
  end
  task automatic check_idle(input string name);
    checks++;
    if (bus.d_out !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s got d_out=%h busy=%b done=%b want all 0", name, bus.d_out, bus.busy, bus.done);
    end
  endtask
  task automatic run(input logic [1:0] sel, input int na, input bit hold);
    exp_t e;
    int n;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      bus.d_in[i] = W'(vin[i]);
      e.v[i] = W'(vexp[i]);
    end
    bus.act_sel = sel;
    bus.num_active = 4'(na);
    bus.start = 1'b1;
    e.cyc = cyc + N + 2;
    q.push_back(e);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start got %b want 1", bus.busy);
    end
    if (!hold) bus.start = 1'b0;
    bus.d_in = '1;
    bus.act_sel = ~sel;
    bus.num_active = 4'(N - na);
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got no done want done within 40 cycles");
      q.delete();
    end
  endtask
  initial begin
    int snap;
    bus.start = 0;
    bus.act_sel = 0;
    bus.num_active = 0;
    bus.d_in = '0;
    repeat (3) @(negedge clk);
    reset = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle("reset_idle");
    end
    vin = '{0, 256, -256, 512, 1536, 1000, 2000, -3000, 77, 9};
    vexp = '{128, 192, 64, 224, 256, 0, 0, 0, 0, 0};
    run(2'b01, 5, 0);
    vin = '{-32768, -1536, 5, 6, 7, 8, 9, 10, 11, 12};
    vexp = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run(2'b01, 2, 0);
    vin = '{608, -608, 1279, 1280, 100, -100, 607, 255, 32767, -1};
    vexp = '{235, 21, 255, 256, 153, 103, 235, 191, 256, 128};
    run(2'b01, 10, 0);
    vin = '{-100, 100, -1, 0, 32767, -32768, 5, -5, 200, -200};
`ifdef ACTIVATION_RELU_EN
    vexp = '{0, 100, 0, 0, 32767, 0, 5, 0, 200, 0};
`else
    vexp = vin;
`endif
    run(2'b10, 10, 0);
    vexp = vin;
    run(2'b00, 12, 0);
    vexp = '{-100, 100, -1, 0, 0, 0, 0, 0, 0, 0};
    run(2'b11, 3, 0);
    vexp = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run(2'b01, 0, 0);
    vin = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    vexp = vin;
    snap = done_cnt;
    run(2'b00, 10, 1);
    repeat (5) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || done_cnt != snap + 1) begin
      errors++;
      $display("FAIL start_held got busy=%b dones=%0d want busy=0 dones=%0d", bus.busy, done_cnt - snap, 1);
    end
    bus.start = 0;
    vin = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10};
    vexp = vin;
    run(2'b00, 10, 0);
    vin = '{0, 256, -256, 512, 1536, 1000, 2000, -3000, 77, 9};
    @(negedge clk);
    for (int i = 0; i < N; i++) bus.d_in[i] = W'(vin[i]);
    bus.act_sel = 2'b01;
    bus.num_active = 4'd10;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    repeat (4) @(negedge clk);
    reset = 1;
    snap = done_cnt;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    check_idle("reset_abort");
    repeat (15) @(negedge clk);
    checks++;
    if (done_cnt != snap) begin
      errors++;
      $display("FAIL abort_no_done got %0d dones want 0", done_cnt - snap);
    end
    vexp = '{128, 192, 64, 224, 256, 0, 0, 0, 0, 0};
    run(2'b01, 5, 0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
